// File: rtl/mem_access_sequencer.sv
// Memory access sequencer: drives the address-mux select and memory port for one
// load/store at a time, waiting out read latency and doing read-modify-write for sub-word stores.
module mem_access_sequencer #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [2:0]  req_src_i,
    input  logic [31:0] req_wdata_i,
    output logic [2:0]  addr_sel_o,
    input  logic [31:0] mem_addr_i,
    output logic        mem_wr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o
);

    localparam logic [2:0] OP_LW = 3'd0;
    localparam logic [2:0] OP_LH = 3'd1;
    localparam logic [2:0] OP_LB = 3'd2;
    localparam logic [2:0] OP_SW = 3'd3;
    localparam logic [2:0] OP_SH = 3'd4;
    localparam logic [2:0] OP_SB = 3'd5;
    localparam logic [2:0] LAST  = 3'(MEM_LAT);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  addr_sel_q, addr_sel_d;
    logic        mem_wr_q, mem_wr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] st_merge;

    // Only the byte offset of the muxed address matters here.
    logic unused_addr;
    assign unused_addr = ^mem_addr_i[31:2];

    always_comb begin
        rd_half  = mem_addr_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        rd_byte  = mem_rdata_i[7:0];
        st_merge = mem_rdata_i;
        case (mem_addr_i[1:0])
            2'd0: rd_byte = mem_rdata_i[7:0];
            2'd1: rd_byte = mem_rdata_i[15:8];
            2'd2: rd_byte = mem_rdata_i[23:16];
            default: rd_byte = mem_rdata_i[31:24];
        endcase
        if (op_q == OP_SH) begin
            if (mem_addr_i[1]) st_merge[31:16] = wdata_q[15:0];
            else               st_merge[15:0]  = wdata_q[15:0];
        end else begin
            case (mem_addr_i[1:0])
                2'd0: st_merge[7:0]   = wdata_q[7:0];
                2'd1: st_merge[15:8]  = wdata_q[7:0];
                2'd2: st_merge[23:16] = wdata_q[7:0];
                default: st_merge[31:24] = wdata_q[7:0];
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        wdata_d     = wdata_q;
        addr_sel_d  = addr_sel_q;
        mem_wr_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    wdata_d = req_wdata_i;
                    cnt_d   = 3'd0;
                    if (req_op_i > OP_SB || req_src_i > 3'd5) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = 32'h0;
                    end else begin
                        addr_sel_d = req_src_i;
                        if (req_op_i == OP_SW) begin
                            state_d     = WRITE;
                            mem_wr_d    = 1'b1;
                            mem_wdata_d = req_wdata_i;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: begin
                if (cnt_q == LAST) begin
                    if (op_q == OP_SH || op_q == OP_SB) begin
                        state_d     = WRITE;
                        mem_wr_d    = 1'b1;
                        mem_wdata_d = st_merge;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        case (op_q)
                            OP_LH:   rsp_data_d = {16'h0, rd_half};
                            OP_LB:   rsp_data_d = {24'h0, rd_byte};
                            default: rsp_data_d = mem_rdata_i;
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            WRITE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = mem_wdata_q;
            end
            default: begin
                state_d    = IDLE;
                addr_sel_d = 3'd0;
                rsp_err_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            op_q        <= OP_LW;
            wdata_q     <= 32'h0;
            addr_sel_q  <= 3'd0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            wdata_q     <= wdata_d;
            addr_sel_q  <= addr_sel_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign addr_sel_o  = addr_sel_q;
    assign mem_wr_o    = mem_wr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: two instances (MEM_LAT 1 and 3) behind a latency-aware
// memory model; transactions are checked against a transaction-level expectation model.
module tb_mem_access_sequencer;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        rv[2];
    logic [2:0]  op, src;
    logic [31:0] wd;
    logic        rdy[2], mwr[2], rval[2], rerr[2];
    logic [2:0]  sel[2];
    logic [31:0] maddr[2], mrd[2], mwd[2], rdat[2];

    logic [31:0] src_addr[6];
    logic [31:0] memw[16];
    logic [31:0] prev_a[2];
    int          stab_q[2];
    int          stab_c[2];

    int errors = 0;
    int checks = 0;

    // Address mux plus a memory whose data is only valid MEM_LAT cycles after the address settles.
    for (genvar g = 0; g < 2; g++) begin : g_mem
        assign maddr[g]  = (sel[g] < 3'd6) ? src_addr[sel[g]] : 32'h0;
        assign stab_c[g] = (maddr[g] == prev_a[g]) ? stab_q[g] : 0;
        assign mrd[g]    = (stab_c[g] >= ((g == 0) ? LAT0 : LAT1)) ? memw[maddr[g][5:2]] : 32'h0BAD_F00D;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            prev_a[i] <= maddr[i];
            stab_q[i] <= (stab_c[i] < 15) ? stab_c[i] + 1 : 15;
        end
    end

    mem_access_sequencer #(.MEM_LAT(LAT0)) u_l1 (
        .clk_i(clk), .reset_i(reset), .req_valid_i(rv[0]), .req_ready_o(rdy[0]),
        .req_op_i(op), .req_src_i(src), .req_wdata_i(wd), .addr_sel_o(sel[0]),
        .mem_addr_i(maddr[0]), .mem_wr_o(mwr[0]), .mem_wdata_o(mwd[0]), .mem_rdata_i(mrd[0]),
        .rsp_valid_o(rval[0]), .rsp_data_o(rdat[0]), .rsp_err_o(rerr[0])
    );

    mem_access_sequencer #(.MEM_LAT(LAT1)) u_l3 (
        .clk_i(clk), .reset_i(reset), .req_valid_i(rv[1]), .req_ready_o(rdy[1]),
        .req_op_i(op), .req_src_i(src), .req_wdata_i(wd), .addr_sel_o(sel[1]),
        .mem_addr_i(maddr[1]), .mem_wr_o(mwr[1]), .mem_wdata_o(mwd[1]), .mem_rdata_i(mrd[1]),
        .rsp_valid_o(rval[1]), .rsp_data_o(rdat[1]), .rsp_err_o(rerr[1])
    );

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({rdy[d], sel[d], mwr[d], mwd[d], rval[d], rdat[d], rerr[d]} !== {1'b1, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0}) begin
                errors++;
                $display("FAIL reset_state dut%0d got rdy=%b sel=%0d wr=%b wd=%h rv=%b rd=%h err=%b exp 1/0/0/0/0/0/0",
                         d, rdy[d], sel[d], mwr[d], mwd[d], rval[d], rdat[d], rerr[d]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One request on DUT d; expectations come straight from the op's documented latency and data rules.
    task automatic run_txn(input int d, input logic [2:0] o, input logic [2:0] s,
                           input logic [31:0] w, input logic [31:0] a, input logic [31:0] rd,
                           input string nm);
        int lat, exp_rsp, exp_wr, exp_nwr, rsp_c, wr_n, wr_c, bad_sel, bad_rdy, sh, wait_c;
        logic [31:0] exp_data, got_data, got_wd, mask;
        logic [2:0]  exp_sel;
        logic        exp_err, got_err;
        lat      = (d == 0) ? LAT0 : LAT1;
        exp_err  = (o > 3'd5) || (s > 3'd5);
        exp_sel  = exp_err ? 3'd0 : s;
        if (!exp_err) begin
            src_addr[s]    = a;
            memw[a[5:2]]   = rd;
        end
        exp_data = 32'h0; exp_rsp = 1; exp_wr = 0; exp_nwr = 0;
        if (!exp_err) begin
            case (o)
                3'd0: begin exp_data = rd; exp_rsp = lat + 2; end
                3'd1: begin sh = a[1] ? 16 : 0; exp_data = (rd >> sh) & 32'hFFFF; exp_rsp = lat + 2; end
                3'd2: begin sh = 8 * int'(a[1:0]); exp_data = (rd >> sh) & 32'hFF; exp_rsp = lat + 2; end
                3'd3: begin exp_data = w; exp_rsp = 2; exp_wr = 1; exp_nwr = 1; end
                3'd4: begin
                    sh = a[1] ? 16 : 0; mask = 32'hFFFF << sh;
                    exp_data = (rd & ~mask) | ((w & 32'hFFFF) << sh);
                    exp_rsp = lat + 3; exp_wr = lat + 2; exp_nwr = 1;
                end
                default: begin
                    sh = 8 * int'(a[1:0]); mask = 32'hFF << sh;
                    exp_data = (rd & ~mask) | ((w & 32'hFF) << sh);
                    exp_rsp = lat + 3; exp_wr = lat + 2; exp_nwr = 1;
                end
            endcase
        end
        wait_c = 0;
        while (!rdy[d] && wait_c < 20) begin @(negedge clk); wait_c++; end
        op = o; src = s; wd = w; rv[d] = 1'b1;
        @(posedge clk);
        rsp_c = 0; wr_n = 0; wr_c = 0; bad_sel = 0; bad_rdy = 0;
        got_data = 32'h0; got_wd = 32'h0; got_err = 1'b0;
        for (int c = 1; c <= 20 && rsp_c == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                rv[d] = 1'b0;
                op = 3'($urandom); src = 3'($urandom); wd = $urandom;
            end
            if (sel[d] !== exp_sel) bad_sel++;
            if (rdy[d] !== 1'b0) bad_rdy++;
            if (mwr[d]) begin wr_n++; wr_c = c; got_wd = mwd[d]; end
            if (rval[d]) begin rsp_c = c; got_data = rdat[d]; got_err = rerr[d]; end
        end
        checks++;
        if (rsp_c != exp_rsp) begin errors++; $display("FAIL %s rsp_cycle got %0d exp %0d", nm, rsp_c, exp_rsp); end
        checks++;
        if (got_data !== exp_data) begin errors++; $display("FAIL %s rsp_data got %h exp %h", nm, got_data, exp_data); end
        checks++;
        if (got_err !== exp_err) begin errors++; $display("FAIL %s rsp_err got %b exp %b", nm, got_err, exp_err); end
        checks++;
        if (wr_n != exp_nwr) begin errors++; $display("FAIL %s mem_wr_count got %0d exp %0d", nm, wr_n, exp_nwr); end
        if (exp_nwr == 1) begin
            checks++;
            if (wr_c != exp_wr || got_wd !== exp_data) begin
                errors++;
                $display("FAIL %s mem_write got cycle %0d data %h exp cycle %0d data %h", nm, wr_c, got_wd, exp_wr, exp_data);
            end
        end
        checks++;
        if (bad_sel != 0 || bad_rdy != 0) begin
            errors++;
            $display("FAIL %s busy_outputs got %0d bad addr_sel / %0d bad ready cycles exp 0 (sel %0d)", nm, bad_sel, bad_rdy, exp_sel);
        end
        @(negedge clk);
        checks++;
        if ({rdy[d], rval[d], sel[d], mwr[d]} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL %s after_resp got rdy=%b rv=%b sel=%0d wr=%b exp 1/0/0/0", nm, rdy[d], rval[d], sel[d], mwr[d]);
        end
    endtask

    task automatic test_directed();
        run_txn(0, 3'd0, 3'd2, 32'h0, 32'h0000_0010, 32'hDEADBEEF, "lw_src2");
        run_txn(0, 3'd2, 3'd1, 32'h0, 32'h0000_0023, 32'h8899AABB, "lb_off3");
        run_txn(0, 3'd1, 3'd3, 32'h0, 32'h0000_0036, 32'h8899AABB, "lh_off2");
        run_txn(0, 3'd5, 3'd5, 32'hFFFFFFAB, 32'h0000_0009, 32'h11223344, "sb_src5_off1");
        run_txn(0, 3'd3, 3'd4, 32'hCAFEF00D, 32'h0000_0014, 32'h0, "sw");
        run_txn(0, 3'd6, 3'd1, 32'h1234, 32'h0, 32'h0, "illegal_op");
        run_txn(0, 3'd0, 3'd7, 32'h1234, 32'h0, 32'h0, "illegal_src");
        run_txn(1, 3'd4, 3'd0, 32'h0000BEEF, 32'h0000_0002, 32'h01234567, "sh_lat3_hi");
        run_txn(1, 3'd0, 3'd3, 32'h0, 32'h0000_0033, 32'hA5A55A5A, "lw_lat3_unaligned");
    endtask

    task automatic test_random();
        logic [2:0] o, s;
        for (int n = 0; n < 40; n++) begin
            o = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
            s = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
            run_txn(n % 2, o, s, $urandom, 32'($urandom_range(0, 63)), $urandom, "random");
        end
    endtask

    task automatic test_reset_mid_write();
        int wait_c, stray;
        src_addr[2] = 32'h0000_0008; memw[2] = 32'h55667788;
        op = 3'd4; src = 3'd2; wd = 32'h0000ABCD; rv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); rv[0] = 1'b0;
        wait_c = 0;
        while (!mwr[0] && wait_c < 10) begin @(negedge clk); wait_c++; end
        checks++;
        if (!mwr[0]) begin errors++; $display("FAIL rst_mid reach_write got mem_wr=%b exp 1", mwr[0]); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({mwr[0], rval[0], rdy[0], sel[0]} !== {1'b0, 1'b0, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL rst_mid after_reset got wr=%b rv=%b rdy=%b sel=%0d exp 0/0/1/0", mwr[0], rval[0], rdy[0], sel[0]);
        end
        reset = 1'b0;
        stray = 0;
        repeat (6) begin @(negedge clk); if (rval[0] || mwr[0]) stray++; end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL rst_mid stray_activity got %0d cycles exp 0", stray); end
    endtask

    task automatic test_reset_collision();
        int stray;
        src_addr[3] = 32'h0000_0004;
        op = 3'd0; src = 3'd3; reset = 1'b1; rv[0] = 1'b1;
        @(negedge clk);
        reset = 1'b0; rv[0] = 1'b0;
        checks++;
        if ({rdy[0], sel[0]} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL rst_collide accepted got rdy=%b sel=%0d exp 1/0", rdy[0], sel[0]);
        end
        stray = 0;
        repeat (6) begin @(negedge clk); if (rval[0] || sel[0] != 3'd0) stray++; end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL rst_collide stray_activity got %0d cycles exp 0", stray); end
    endtask

    // LW then SW with req_valid held high; the request inputs change right after the first accept.
    task automatic test_back_to_back();
        int rsp1, rsp2, rdy_c, wr_c, bad_sel;
        logic [31:0] d1, d2, wd2;
        src_addr[1] = 32'h0000_0020; memw[8] = 32'h13579BDF;
        src_addr[4] = 32'h0000_0030;
        op = 3'd0; src = 3'd1; wd = 32'h0; rv[1] = 1'b1;
        @(posedge clk);
        rsp1 = 0; rsp2 = 0; rdy_c = 0; wr_c = 0; bad_sel = 0; d1 = 0; d2 = 0; wd2 = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) begin op = 3'd3; src = 3'd4; wd = 32'hFEEDFACE; end
            if (c == LAT1 + 4) rv[1] = 1'b0;
            if (c <= LAT1 + 2 && sel[1] !== 3'd1) bad_sel++;
            if (c == LAT1 + 4 && sel[1] !== 3'd4) bad_sel++;
            if (rdy[1] && rdy_c == 0) rdy_c = c;
            if (mwr[1]) begin wr_c = c; wd2 = mwd[1]; end
            if (rval[1]) begin
                if (rsp1 == 0) begin rsp1 = c; d1 = rdat[1]; end
                else if (rsp2 == 0) begin rsp2 = c; d2 = rdat[1]; end
            end
        end
        checks++;
        if (rsp1 != LAT1 + 2 || d1 !== 32'h13579BDF) begin
            errors++; $display("FAIL b2b first_rsp got cycle %0d data %h exp %0d 13579bdf", rsp1, d1, LAT1 + 2);
        end
        checks++;
        if (rdy_c != LAT1 + 3) begin errors++; $display("FAIL b2b ready_cycle got %0d exp %0d", rdy_c, LAT1 + 3); end
        checks++;
        if (wr_c != LAT1 + 4 || wd2 !== 32'hFEEDFACE) begin
            errors++; $display("FAIL b2b second_write got cycle %0d data %h exp %0d feedface", wr_c, wd2, LAT1 + 4);
        end
        checks++;
        if (rsp2 != LAT1 + 5 || d2 !== 32'hFEEDFACE) begin
            errors++; $display("FAIL b2b second_rsp got cycle %0d data %h exp %0d feedface", rsp2, d2, LAT1 + 5);
        end
        checks++;
        if (bad_sel != 0) begin errors++; $display("FAIL b2b addr_sel got %0d bad cycles exp 0", bad_sel); end
    endtask

    initial begin
        rv[0] = 1'b0; rv[1] = 1'b0; reset = 1'b1;
        op = 3'd0; src = 3'd0; wd = 32'h0;
        for (int i = 0; i < 6; i++) src_addr[i] = 32'h0;
        for (int i = 0; i < 16; i++) memw[i] = 32'h0;
        test_reset();
        test_directed();
        test_reset_mid_write();
        test_reset_collision();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Multi-cycle sequencer that owns the memory-address source mux (six 32-bit sources, 3-bit select) and the memory port in the multicycle CPU. It accepts one load/store request at a time from the main control unit and drives the mux select for the whole access. It waits out the memory read latency and performs read-modify-write for sub-word stores. It then returns zero-extended load data or a completion pulse. This lets the main FSM issue a single request instead of sequencing every memory cycle itself.

## Interface
- MEM_LAT, 1, cycles from a stable address on mem_addr to valid mem_rdata (1..7)
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request strobe from control unit
- req_ready  out  1  high only in IDLE; a request is accepted on a clk edge where req_valid && req_ready
- req_op  in  3  000 LW, 001 LH, 010 LB, 011 SW, 100 SH, 101 SB; 110/111 illegal
- req_src  in  3  address source index 0..5; 6/7 illegal
- req_wdata  in  32  store data (SH uses [15:0], SB uses [7:0])
- addr_sel  out  3  select driven to the address mux
- mem_addr  in  32  mux output, fed back for byte offset only
- mem_wr  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  32  load result / written word; holds last value between pulses
- rsp_err  out  1  valid with rsp_valid; 1 = illegal op or src

## Operation
- All outputs are registered except req_ready = (state == IDLE).
- Reset values: state IDLE, addr_sel 000, mem_wr 0, mem_wdata 0, rsp_valid 0, rsp_data 0, rsp_err 0, counter 0.
- States: IDLE, READ, WRITE, RESP.
- IDLE, on accept:
  - Capture op, src, wdata.
  - Illegal op/src -> RESP with err.
  - Otherwise addr_sel <= src. SW -> WRITE; all other ops -> READ.
- READ:
  - Lasts MEM_LAT+1 cycles (counter 0..MEM_LAT). mem_wr = 0.
  - On the last READ cycle, latch mem_rdata and off = mem_addr[1:0].
  - Loads -> RESP. SH/SB -> WRITE.
- WRITE (one cycle):
  - mem_wr = 1.
  - SW: mem_wdata = wdata.
  - SH: latched word with half lane off[1] (lane 0 = [15:0], lane 1 = [31:16]) replaced by wdata[15:0].
  - SB: latched word with byte lane off (lane k = [8k+7:8k]) replaced by wdata[7:0].
  - -> RESP.
- RESP (one cycle):
  - rsp_valid = 1; addr_sel returns to 000; mem_wr = 0.
  - rsp_data:
    - LW: the word.
    - LH: zero-extended lane off[1].
    - LB: zero-extended lane off.
    - Stores: the word written.
    - Illegal: 0.
  - rsp_err = 1 only for illegal requests.
  - -> IDLE.
- Alignment: addr[0] is ignored for halfwords; addr[1:0] is ignored for words. No misalignment error.
- addr_sel is held constant from the cycle after accept until RESP.

## Timing
- Accept at edge 0 (cycle 0). addr_sel is valid from cycle 1.
- rsp_valid asserted in cycle:
  - SW: 2 (WRITE in cycle 1).
  - Loads: MEM_LAT+2.
  - SH/SB: MEM_LAT+3 (WRITE in cycle MEM_LAT+2).
  - Illegal: 1.
- mem_wr is high for exactly one cycle per store and never during loads.
- Back-to-back: req_ready rises the cycle after RESP. Minimum issue interval = latency + 1.
- req_valid while not ready is ignored; inputs are not re-sampled.
- Reset mid-operation: at the reset edge all registers take reset values. Any pending write is dropped (mem_wr 0 next cycle). No rsp_valid is generated for the aborted request.
- Simultaneous reset and req_valid: reset wins; the request is not accepted.

## Test plan
- LW src=2, MEM_LAT=1, mem_rdata=0xDEADBEEF -> addr_sel=2 in cycles 1-3; rsp_valid in cycle 3; rsp_data=0xDEADBEEF; mem_wr never high.
- LB with mem_addr[1:0]=3 and LH with mem_addr[1]=1, rdata=0x8899AABB -> rsp_data=0x00000088 and 0x00008899.
- SB src=5, off=1, rdata=0x11223344, wdata=0xFFFFFFAB -> one mem_wr pulse in cycle 3 with mem_wdata=0x1122AB44; rsp_valid cycle 4; rsp_data=0x1122AB44.
- SW wdata=0xCAFEF00D -> mem_wr in cycle 1; rsp_valid cycle 2. req_op=110 or req_src=7 -> rsp_valid cycle 1, rsp_err=1, rsp_data=0, no mem_wr.
- Reset asserted during WRITE of SH -> mem_wr 0 the following cycle; no rsp_valid; req_ready=1, addr_sel=000 after reset.
- MEM_LAT=3, back-to-back LW/SW with req_valid held high -> second accept in the cycle after the first RESP; req_valid while busy is ignored.
